// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : core_sequencer
//  Purpose  : Multi-cycle instruction sequencer. Walks each instruction
//             through FETCH/DECODE/EXEC/MEM/WB over one shared memory port
//             and issues single-cycle enables to PC, IR, MDR and regfile.
//             A memory request that stalls too long faults into HALT.
//  Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
  parameter int TIMEOUT   = 16,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 instr_halt,
  input  logic                 regwrite_in,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_sel,
  output logic                 ir_load,
  output logic                 mdr_load,
  output logic                 pc_en,
  output logic                 reg_en,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [INSTRET_W-1:0] instret
);

  // Wait counter only has to reach TIMEOUT-1; TIMEOUT >= 2 keeps this >= 1 bit.
  localparam int                c_wait_w    = $clog2(TIMEOUT);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_wait_w-1:0]    r_wait;
  logic                   r_err;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   w_req_state;
  logic                   w_timeout;

  // A request cycle without ready while the counter sits at its last value is
  // the TIMEOUT-th unanswered cycle; ready in that same cycle still completes.
  assign w_req_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = w_req_state && !mem_ready && (r_wait == c_wait_last);

  // Next-state decode plus Moore/Mealy control outputs.
  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    pc_en    = 1'b0;
    reg_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || step) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready && !reset;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: begin
        w_next = instr_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_next = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_sel  = 1'b1;
        mem_we   = is_store;
        mdr_load = mem_ready && !is_store && !reset;
        if (mem_ready)      w_next = S_WB;
        else if (w_timeout) w_next = S_HALT;
      end
      S_WB: begin
        // Gated by reset so an abandoned instruction never commits.
        pc_en  = !reset;
        reg_en = regwrite_in && !is_store && !reset;
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Memory wait counter: counts unanswered request cycles, zero elsewhere so
  // every FETCH/MEM entry starts from a clean count.
  always_ff @(posedge clk) begin
    if (reset)
      r_wait <= '0;
    else if (w_req_state && !mem_ready && (r_wait != c_wait_last))
      r_wait <= r_wait + 1'b1;
    else
      r_wait <= '0;
  end

  // Sticky timeout fault flag.
  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset)                r_instret <= '0;
    else if (r_state == S_WB) r_instret <= r_instret + 1'b1;
  end

  assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted  = (r_state == S_HALT);
  assign err     = r_err;
  assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_core_sequencer
//  Purpose  : Self-checking bench for core_sequencer. Expected timing is
//             derived per instruction from phase lengths and wait counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam int c_tw = 4;

  logic            clk;
  logic            reset;
  logic            run;
  logic            step;
  logic            is_load;
  logic            is_store;
  logic            instr_halt;
  logic            regwrite_in;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            mem_sel;
  logic            ir_load;
  logic            mdr_load;
  logic            pc_en;
  logic            reg_en;
  logic            busy;
  logic            halted;
  logic            err;
  logic [c_tw-1:0] instret;

  int checks;
  int failures;
  int exp_instret;

  core_sequencer #(.TIMEOUT(16), .INSTRET_W(c_tw)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .is_load(is_load),
    .is_store(is_store), .instr_halt(instr_halt), .regwrite_in(regwrite_in),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .ir_load(ir_load), .mdr_load(mdr_load),
    .pc_en(pc_en), .reg_en(reg_en), .busy(busy), .halted(halted),
    .err(err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [c_tw-1:0] model_cnt(input int n);
    int m;
    m = n % 16;
    return m[c_tw-1:0];
  endfunction

  // Next cycle is IDLE on entry; launches via run or step.
  task automatic start(input bit use_step);
    @(posedge clk); #1;
    if (use_step) step = 1'b1;
    else          run  = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    exp_instret = 0;
  endtask

  // Runs one instruction starting in its FETCH cycle. kind: 0 ALU, 1 load, 2 store.
  // Expected length = fetch(fw+1) + decode + exec + mem(mw+1 if memop) + wb.
  task automatic do_instr(input int kind, input int fw, input int mw, input bit rw,
                          input int step_at, input int drop_at);
    int len, pc_n, pc_at, mdr_n, mdr_at, ir_n, we_n, fcnt, mcnt, reg_bad;
    bit memop;
    memop = (kind != 0);
    len = fw + 1 + 2 + (memop ? mw + 1 : 0) + 1;
    pc_n = 0; pc_at = -1; mdr_n = 0; mdr_at = -1; ir_n = 0; we_n = 0;
    fcnt = 0; mcnt = 0; reg_bad = 0;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        is_load = (kind == 1); is_store = (kind == 2);
        regwrite_in = rw; instr_halt = 1'b0;
      end
      step = (k == step_at);
      if (k == drop_at) run = 1'b0;
      if (mem_req === 1'b1) begin
        if (mem_sel === 1'b0) begin mem_ready = (fcnt == fw); fcnt++; end
        else                  begin mem_ready = (mcnt == mw); mcnt++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (instret !== model_cnt(exp_instret)) begin
          failures++;
          $display("FAIL instret_start: got %0d want %0d", instret, model_cnt(exp_instret));
        end
      end
      if (pc_en === 1'b1) begin
        pc_n++; pc_at = k;
        if (reg_en !== (rw && kind != 2)) reg_bad++;
      end else if (reg_en !== 1'b0) begin
        reg_bad++;
      end
      if (ir_load === 1'b1) ir_n++;
      if (mdr_load === 1'b1) begin mdr_n++; mdr_at = k; end
      if (mem_req === 1'b1 && mem_we === 1'b1) we_n++;
    end
    step = 1'b0;
    checks++;
    if (pc_n != 1 || pc_at != len) begin
      failures++;
      $display("FAIL pc_en_timing: kind=%0d fw=%0d mw=%0d got %0d pulses at cycle %0d want 1 at %0d",
               kind, fw, mw, pc_n, pc_at, len);
    end
    checks++;
    if (reg_bad != 0) begin
      failures++;
      $display("FAIL reg_en: kind=%0d rw=%0d got %0d bad cycles want 0", kind, rw, reg_bad);
    end
    checks++;
    if (ir_n != 1) begin
      failures++;
      $display("FAIL ir_load_count: got %0d want 1", ir_n);
    end
    checks++;
    if (mdr_n != (kind == 1 ? 1 : 0) || (kind == 1 && mdr_at != len - 1)) begin
      failures++;
      $display("FAIL mdr_load: kind=%0d got %0d pulses at %0d want %0d at %0d",
               kind, mdr_n, mdr_at, (kind == 1 ? 1 : 0), len - 1);
    end
    checks++;
    if (we_n != (kind == 2 ? mw + 1 : 0)) begin
      failures++;
      $display("FAIL mem_we_cycles: got %0d want %0d", we_n, (kind == 2 ? mw + 1 : 0));
    end
    exp_instret = (exp_instret + 1) % 16;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || instret !== model_cnt(exp_instret)) begin
      failures++;
      $display("FAIL %s: busy=%b instret=%0d want busy=0 instret=%0d",
               tag, busy, instret, model_cnt(exp_instret));
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b1; step = 1'b1; mem_ready = 1'b1;
    is_load = 1'b1; is_store = 1'b0; regwrite_in = 1'b1; instr_halt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_sel, ir_load, mdr_load, pc_en, reg_en, busy, halted, err} !== 10'b0
        || instret !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b instret=%0d want all zero",
               {mem_req, mem_we, mem_sel, ir_load, mdr_load, pc_en, reg_en, busy, halted, err}, instret);
    end
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clk);
    exp_instret = 0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b mem_req=%b want 0 0", busy, mem_req);
    end
  endtask

  task automatic test_run_alu();
    start(1'b0);
    do_instr(0, 0, 0, 1'b1, 0, 0);
    do_instr(0, 0, 0, 1'b1, 0, 0);
    do_instr(0, 0, 0, 1'b1, 0, 1);
    idle_check("run_alu_end");
  endtask

  task automatic test_step_load();
    start(1'b1);
    do_instr(1, 0, 0, 1'b1, 2, 0);
    idle_check("step_load_end");
  endtask

  task automatic test_store_wait();
    start(1'b0);
    do_instr(2, 0, 3, 1'b1, 0, 1);
    idle_check("store_wait_end");
  endtask

  task automatic test_back_to_back();
    int n;
    n = 10;
    start(1'b0);
    for (int i = 0; i < n; i++)
      do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0,
               (i == n - 1) ? int'($urandom_range(1, 3)) : 0);
    idle_check("back_to_back_end");
  endtask

  task automatic test_timeout();
    int req_n, first_halt;
    req_n = 0; first_halt = -1;
    is_load = 1'b0; is_store = 1'b0;
    start(1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      if (mem_req === 1'b1) req_n++;
      if (halted === 1'b1 && first_halt < 0) first_halt = k;
    end
    checks++;
    if (req_n != 16 || first_halt != 17) begin
      failures++;
      $display("FAIL timeout_len: got %0d req cycles halt at %0d want 16 at 17", req_n, first_halt);
    end
    checks++;
    if (halted !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: halted=%b err=%b mem_req=%b busy=%b want 1 1 0 0",
               halted, err, mem_req, busy);
    end
    apply_reset();
    checks++;
    if (err !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset: err=%b halted=%b want 0 0", err, halted);
    end
    start(1'b0);
    do_instr(0, 15, 0, 1'b1, 0, 1);
    checks++;
    if (err !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL ready_on_last: err=%b halted=%b want 0 0", err, halted);
    end
    idle_check("ready_on_last_end");
  endtask

  task automatic test_halt();
    int pc_n, not_halt;
    pc_n = 0; not_halt = 0;
    is_load = 1'b0; is_store = 1'b0; instr_halt = 1'b1;
    start(1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k >= 3) begin run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      if (pc_en !== 1'b0 || reg_en !== 1'b0) pc_n++;
      if (k >= 3 && (halted !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0)) not_halt++;
    end
    run = 1'b0; step = 1'b0; instr_halt = 1'b0;
    checks++;
    if (pc_n != 0 || not_halt != 0) begin
      failures++;
      $display("FAIL halt_hold: got %0d enable cycles %0d non-halt cycles want 0 0", pc_n, not_halt);
    end
    checks++;
    if (instret !== model_cnt(exp_instret)) begin
      failures++;
      $display("FAIL halt_instret: got %0d want %0d", instret, model_cnt(exp_instret));
    end
    apply_reset();
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset: halted=%b want 0", halted);
    end
  endtask

  task automatic test_reset_mid();
    start(1'b1);
    do_instr(0, 0, 0, 1'b1, 0, 0);
    idle_check("pre_reset_mid");
    start(1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin is_store = 1'b1; is_load = 1'b0; regwrite_in = 1'b1; end
      mem_ready = (k == 1);
      if (k == 5) reset = 1'b1;
      if (k == 6) begin reset = 1'b0; run = 1'b0; end
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (pc_en !== 1'b0 || reg_en !== 1'b0 || mem_req !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid_cycle: pc_en=%b reg_en=%b mem_req=%b want 0 0 1",
                   pc_en, reg_en, mem_req);
        end
      end
      if (k == 6) begin
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || instret !== 4'd0 || err !== 1'b0
            || pc_en !== 1'b0 || reg_en !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_after: mem_req=%b busy=%b instret=%0d err=%b pc_en=%b reg_en=%b want all 0",
                   mem_req, busy, instret, err, pc_en, reg_en);
        end
      end
    end
    exp_instret = 0;
    is_store = 1'b0; is_load = 1'b1;
    start(1'b0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ir_load !== 1'b0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch_irload: ir_load=%b mem_req=%b want 0 1", ir_load, mem_req);
    end
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_fetch_after: busy=%b mem_req=%b want 0 0", busy, mem_req);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    start(1'b0);
    for (int i = 0; i < 16; i++)
      do_instr(0, 0, 0, 1'b1, 0, (i == 15) ? 1 : 0);
    idle_check("wrap_end");
    checks++;
    if (instret !== 4'd0) begin
      failures++;
      $display("FAIL instret_wrap: got %0d want 0", instret);
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_instret = 0;
    reset = 1'b0; run = 1'b0; step = 1'b0; is_load = 1'b0; is_store = 1'b0;
    instr_halt = 1'b0; regwrite_in = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_run_alu();
    test_step_load();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle execution sequencer for the RISC-V core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB phases over a single shared instruction/data memory port, and issues one-cycle enables to the PC, instruction register, memory data register and register file. Sits between the top-level `run` control and the datapath. The decode controller feeds it instruction class and `RegWrite`.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles a memory request may wait for `mem_ready` before the block faults (≥2).
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `run` input 1: level; continuous execution while high.
- `step` input 1: pulse; execute exactly one instruction when idle.
- `is_load` input 1: decoded instruction is a load; valid from DECODE onward.
- `is_store` input 1: decoded instruction is a store; valid from DECODE onward.
- `instr_halt` input 1: decoded instruction is EBREAK/ECALL; sampled in DECODE.
- `regwrite_in` input 1: `RegWrite` from the decode controller.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request active.
- `mem_we` output 1: request is a write.
- `mem_sel` output 1: 0 = instruction address (PC), 1 = data address (ALU result).
- `ir_load` output 1: instruction register captures memory read data.
- `mdr_load` output 1: memory data register captures load data.
- `pc_en` output 1: PC register updates to its next value.
- `reg_en` output 1: register file write enable.
- `busy` output 1: state ∉ {IDLE, HALT}.
- `halted` output 1: state == HALT.
- `err` output 1: memory timeout fault (sticky).
- `instret` output INSTRET_W: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - → FETCH if `run` or `step`.
  - `step` is ignored in every state other than IDLE.
- FETCH:
  - `mem_req`=1, `mem_sel`=0, `mem_we`=0.
  - → DECODE on `mem_ready`; `ir_load`=mem_ready in the same cycle (combinational).
- DECODE:
  - → HALT if `instr_halt`, otherwise → EXEC.
- EXEC:
  - → MEM if `is_load`|`is_store`, otherwise → WB.
- MEM:
  - `mem_req`=1, `mem_sel`=1, `mem_we`=`is_store`.
  - → WB on `mem_ready`; `mdr_load`=mem_ready & ~is_store.
- WB:
  - `pc_en`=1.
  - `reg_en`=`regwrite_in` & ~`is_store`.
  - `instret` increments, wrapping modulo 2^INSTRET_W.
  - → FETCH if `run`, otherwise → IDLE.
  - Therefore `step` retires exactly one instruction, and `run` dropping mid-instruction completes that instruction and then stops.
- HALT:
  - All enables 0.
  - Left only by `reset`.
  - A halting instruction does not retire: no `pc_en`, no `instret` increment.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM.
  - Counter increments each FETCH/MEM cycle with `mem_ready`=0.
  - If `mem_ready`=0 while the counter == TIMEOUT-1 → HALT, `err`=1, `mem_req` low from the next cycle.
  - `mem_ready` on the TIMEOUT-th request cycle still completes normally.
- `mem_ready` outside FETCH/MEM is ignored.
- Handshake: `mem_req`, `mem_sel` and `mem_we` are held stable from first assertion until the completing cycle.

## Timing
- Reset: state IDLE; `instret`=0, `err`=0.
  - All outputs are 0 in the cycle after reset is sampled.
  - Mealy outputs (`ir_load`, `mdr_load`) are forced 0 while `reset`=1.
- Reset mid-operation: the instruction in flight is abandoned.
  - No `pc_en`/`reg_en` issues in the reset cycle or afterwards.
  - `mem_req` drops at the next edge.
- Latency with zero-wait memory (`mem_ready` tied high), measured as cycles per instruction from FETCH entry:
  - ALU/branch: 4 (FETCH, DECODE, EXEC, WB).
  - Load/store: 5.
- Each memory wait cycle adds 1.
- IDLE → FETCH takes one cycle after `run`/`step` is sampled high.
- Back-to-back under `run`: WB is immediately followed by FETCH, with no bubble.
- `pc_en` and `reg_en` are asserted for exactly one cycle per retired instruction.

## Test plan
- Reset, then `run`=1 with `mem_ready`=1 and 3 ALU instructions (`regwrite_in`=1) → `pc_en` pulses every 4 cycles; `instret`=3 after 12 cycles; `reg_en` coincides with `pc_en`.
- `step` pulse with a load, `mem_ready`=1 → `mdr_load` in cycle 4, `reg_en`+`pc_en` in cycle 5, back to IDLE, `instret`=1.
  - A second `step` during busy is ignored.
- Store with `mem_ready` delayed 3 cycles in MEM → `mem_req`/`mem_sel`=1/`mem_we`=1 held for 4 cycles; `reg_en`=0 in WB; total 8 cycles.
- FETCH with `mem_ready` held 0 (TIMEOUT=16) → after 16 request cycles: `halted`=1, `err`=1, `mem_req`=0.
  - Repeat with ready on cycle 16 → normal completion, `err`=0.
- `instr_halt`=1 in DECODE → HALT; `pc_en` never pulses; `instret` unchanged; `run` toggling has no effect until `reset`.
- `reset` asserted in MEM during a store wait → next cycle IDLE, `mem_req`=0, no `pc_en`/`reg_en`, `instret` and `err` cleared.
- `instret` preloaded near wrap (INSTRET_W=4, 16 retirements) → counter wraps to 0.
